tmr_fault_mgr: RTL and testbench

TMR_FAULT_MGR -- requirements
Module: tmr_fault_mgr

---
 rtl/tmr_fault_mgr.sv | 184 ++++++++++++++++++
 tb/tb_tmr_fault_mgr.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_fault_mgr.sv
// Triple-modular-redundancy voter with fault masking, resynchronisation handshake
// and recovery qualification; the FSM state is exported on `state` for observability.
module tmr_fault_mgr #(
    parameter int WIDTH        = 8,
    parameter int CNT_W        = 8,
    parameter int FAULT_THRESH = 4,
    parameter int RECOVER_LEN  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             resync_ack,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic [1:0]       fault_id,
    output logic             resync_req,
    output logic             unc_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] err_cnt_a,
    output logic [CNT_W-1:0] err_cnt_b,
    output logic [CNT_W-1:0] err_cnt_c
);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_DEGRADED = 2'd1,
        ST_RECOVER  = 2'd2,
        ST_FAIL     = 2'd3
    } state_t;

    localparam logic [3:0] THR = 4'(FAULT_THRESH);
    localparam logic [3:0] RLN = 4'(RECOVER_LEN);

    state_t           cur;
    logic [3:0]       streak     [0:2];
    logic [3:0]       streak_nxt [0:2];
    logic [CNT_W-1:0] err        [0:2];
    logic [3:0]       rec_cnt;

    logic [WIDTH-1:0] maj;
    logic [WIDTH-1:0] h0;
    logic [WIDTH-1:0] h1;
    logic [WIDTH-1:0] ref_val;
    logic             agree;
    logic [2:0]       mis;
    logic [2:0]       hit;
    logic [1:0]       hit_id;
    logic             masked_mis;
    logic             sample_ok;

    assign state     = cur;
    assign err_cnt_a = err[0];
    assign err_cnt_b = err[1];
    assign err_cnt_c = err[2];

    // Handshake: valid_in qualifies a/b/c for one cycle (no backpressure);
    // y_valid pulses for one cycle when y carries a freshly voted sample.
    always_comb begin
        maj = (a & b) | (b & c) | (a & c);
        h0  = b;
        h1  = c;
        case (fault_id)
            2'd2:    begin h0 = a; h1 = c; end
            2'd3:    begin h0 = a; h1 = b; end
            default: begin h0 = b; h1 = c; end
        endcase
        agree   = (h0 == h1);
        ref_val = (cur == ST_NORMAL) ? maj : h0;
        mis     = {(c != ref_val), (b != ref_val), (a != ref_val)};
        // A sample is only scored when a trustworthy reference exists.
        sample_ok = valid_in &&
                    ((cur == ST_NORMAL) ||
                     (((cur == ST_DEGRADED) || (cur == ST_RECOVER)) && agree));
        hit = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (mis[i])
                streak_nxt[i] = (streak[i] == THR) ? THR : streak[i] + 4'd1;
            else
                streak_nxt[i] = 4'd0;
            hit[i] = (streak_nxt[i] == THR);
        end
        if (hit[0])      hit_id = 2'd1;
        else if (hit[1]) hit_id = 2'd2;
        else if (hit[2]) hit_id = 2'd3;
        else             hit_id = 2'd0;
        case (fault_id)
            2'd1:    masked_mis = mis[0];
            2'd2:    masked_mis = mis[1];
            2'd3:    masked_mis = mis[2];
            default: masked_mis = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= ST_NORMAL;
            y          <= '0;
            y_valid    <= 1'b0;
            fault_id   <= 2'd0;
            resync_req <= 1'b0;
            unc_err    <= 1'b0;
            rec_cnt    <= 4'd0;
            for (int i = 0; i < 3; i++) begin
                streak[i] <= 4'd0;
                err[i]    <= '0;
            end
        end else begin
            y_valid <= 1'b0;

            for (int i = 0; i < 3; i++) begin
                if (clr_cnt)
                    err[i] <= '0;
                else if (sample_ok && mis[i] && (err[i] != {CNT_W{1'b1}}))
                    err[i] <= err[i] + CNT_W'(1);
                if (sample_ok)
                    streak[i] <= streak_nxt[i];
            end

            case (cur)
                ST_NORMAL: begin
                    if (valid_in) begin
                        y       <= maj;
                        y_valid <= 1'b1;
                        if (hit != 3'b000) begin
                            cur        <= ST_DEGRADED;
                            fault_id   <= hit_id;
                            resync_req <= 1'b1;
                        end
                    end
                end

                ST_DEGRADED: begin
                    if (valid_in && !agree) begin
                        cur        <= ST_FAIL;
                        unc_err    <= 1'b1;
                        resync_req <= 1'b0;
                    end else begin
                        if (valid_in) begin
                            y       <= h0;
                            y_valid <= 1'b1;
                        end
                        if (resync_ack && resync_req) begin
                            cur        <= ST_RECOVER;
                            resync_req <= 1'b0;
                            rec_cnt    <= 4'd0;
                        end
                    end
                end

                ST_RECOVER: begin
                    if (valid_in && !agree) begin
                        cur        <= ST_FAIL;
                        unc_err    <= 1'b1;
                        resync_req <= 1'b0;
                    end else if (valid_in) begin
                        y       <= h0;
                        y_valid <= 1'b1;
                        if (masked_mis) begin
                            cur        <= ST_DEGRADED;
                            resync_req <= 1'b1;
                        end else if (rec_cnt + 4'd1 == RLN) begin
                            // Re-admission: forget any history gathered while masked.
                            cur      <= ST_NORMAL;
                            fault_id <= 2'd0;
                            for (int i = 0; i < 3; i++)
                                streak[i] <= 4'd0;
                        end else begin
                            rec_cnt <= rec_cnt + 4'd1;
                        end
                    end
                end

                default: begin
                    resync_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmr_fault_mgr.sv
// Bench for tmr_fault_mgr: directed vector table, hand-written corner sequences
// and randomized traffic scored against a behavioural model.
module tb_tmr_fault_mgr;

    localparam int TH = 4;
    localparam int RL = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] a = '0, b = '0, c = '0;
    logic       resync_ack = 1'b0;
    logic       clr_cnt = 1'b0;
    logic [7:0] y;
    logic       y_valid;
    logic [1:0] fault_id;
    logic       resync_req;
    logic       unc_err;
    logic [1:0] state;
    logic [7:0] err_cnt_a, err_cnt_b, err_cnt_c;

    int n_checks = 0;
    int n_errors = 0;

    tmr_fault_mgr #(.WIDTH(8), .CNT_W(8), .FAULT_THRESH(TH), .RECOVER_LEN(RL)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .a(a), .b(b), .c(c),
        .resync_ack(resync_ack), .clr_cnt(clr_cnt), .y(y), .y_valid(y_valid),
        .fault_id(fault_id), .resync_req(resync_req), .unc_err(unc_err), .state(state),
        .err_cnt_a(err_cnt_a), .err_cnt_b(err_cnt_b), .err_cnt_c(err_cnt_c)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] ia, ib, ic;
        logic       ack, clr;
        logic [7:0] ey;
        logic       eyv;
        logic [1:0] est, efid;
        logic       ereq, eunc;
        logic [7:0] ea, eb, ec;
    } vec_t;

    vec_t tv[20];

    function automatic vec_t mk(logic v, logic [7:0] ia, ib, ic, logic ack, clr,
                                logic [7:0] ey, logic eyv, logic [1:0] est, efid,
                                logic ereq, eunc, logic [7:0] ea, eb, ec);
        vec_t t;
        t.v = v; t.ia = ia; t.ib = ib; t.ic = ic; t.ack = ack; t.clr = clr;
        t.ey = ey; t.eyv = eyv; t.est = est; t.efid = efid; t.ereq = ereq; t.eunc = eunc;
        t.ea = ea; t.eb = eb; t.ec = ec;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] ey, input logic eyv,
                             input logic [1:0] est, input logic [1:0] efid,
                             input logic ereq, input logic eunc,
                             input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ec);
        check({tag, ".y"}, 32'(y), 32'(ey));
        check({tag, ".y_valid"}, 32'(y_valid), 32'(eyv));
        check({tag, ".state"}, 32'(state), 32'(est));
        check({tag, ".fault_id"}, 32'(fault_id), 32'(efid));
        check({tag, ".resync_req"}, 32'(resync_req), 32'(ereq));
        check({tag, ".unc_err"}, 32'(unc_err), 32'(eunc));
        check({tag, ".err_cnt_a"}, 32'(err_cnt_a), 32'(ea));
        check({tag, ".err_cnt_b"}, 32'(err_cnt_b), 32'(eb));
        check({tag, ".err_cnt_c"}, 32'(err_cnt_c), 32'(ec));
    endtask

    task automatic apply(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [7:0] ic, input logic ack, input logic clr);
        @(negedge clk);
        valid_in = v; a = ia; b = ib; c = ic; resync_ack = ack; clr_cnt = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        valid_in = 1'b0; a = '0; b = '0; c = '0; resync_ack = 1'b0; clr_cnt = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Behavioural reference: state as small integers, voting bit by bit.
    int         m_state, m_fault, m_req, m_unc, m_yv, m_rec;
    logic [7:0] m_y;
    int         m_streak[3];
    int         m_cnt[3];

    function automatic void model_reset();
        m_state = 0; m_fault = 0; m_req = 0; m_unc = 0; m_yv = 0; m_rec = 0; m_y = '0;
        for (int i = 0; i < 3; i++) begin m_streak[i] = 0; m_cnt[i] = 0; end
    endfunction

    function automatic void model_step(input logic v, input logic [7:0] d0, d1, d2,
                                       input logic ack, input logic clr);
        logic [7:0] d[3];
        logic [7:0] r;
        int         cur, h0, h1, ones;
        bit         ok;
        d[0] = d0; d[1] = d1; d[2] = d2;
        cur = m_state;
        m_yv = 0;
        r = '0;
        ok = 1'b1;
        if (v && cur != 3) begin
            if (cur == 0) begin
                for (int k = 0; k < 8; k++) begin
                    ones = int'(d[0][k]) + int'(d[1][k]) + int'(d[2][k]);
                    r[k] = (ones >= 2);
                end
            end else begin
                h0 = (m_fault == 1) ? 1 : 0;
                h1 = (m_fault == 3) ? 1 : 2;
                ok = (d[h0] == d[h1]);
                r  = d[h0];
            end
            if (!ok) begin
                m_state = 3; m_unc = 1; m_req = 0;
            end else begin
                m_y = r; m_yv = 1;
                for (int i = 0; i < 3; i++) begin
                    if (d[i] != r) begin
                        m_streak[i] = (m_streak[i] + 1 > TH) ? TH : m_streak[i] + 1;
                        m_cnt[i]    = (m_cnt[i] + 1 > 255) ? 255 : m_cnt[i] + 1;
                    end else begin
                        m_streak[i] = 0;
                    end
                end
                if (cur == 0) begin
                    for (int i = 2; i >= 0; i--)
                        if (m_streak[i] == TH) begin
                            m_state = 1; m_fault = i + 1; m_req = 1;
                        end
                end else if (cur == 2) begin
                    if (d[m_fault-1] != r) begin
                        m_state = 1; m_req = 1;
                    end else begin
                        m_rec++;
                        if (m_rec == RL) begin
                            m_state = 0; m_fault = 0;
                            for (int i = 0; i < 3; i++) m_streak[i] = 0;
                        end
                    end
                end
            end
        end
        if (cur == 1 && m_state != 3 && ack) begin
            m_state = 2; m_req = 0; m_rec = 0;
        end
        if (clr)
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    endfunction

    initial begin
        logic [7:0] d[3];
        logic [7:0] base;
        logic       v, ack, clr;
        int         fc;

        tv[0]  = mk(1, 8'h5A, 8'h5A, 8'h5A, 0, 0, 8'h5A, 1, 0, 0, 0, 0, 0, 0, 0);
        tv[1]  = mk(1, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0);
        tv[2]  = mk(1, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0, 2, 0, 0);
        tv[3]  = mk(1, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0, 3, 0, 0);
        tv[4]  = mk(1, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0, 3, 0, 0);
        tv[5]  = mk(0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3, 0, 0);
        tv[6]  = mk(1, 8'h22, 8'h11, 8'h22, 0, 0, 8'h22, 1, 0, 0, 0, 0, 3, 1, 0);
        tv[7]  = mk(1, 8'h22, 8'h11, 8'h22, 0, 0, 8'h22, 1, 0, 0, 0, 0, 3, 2, 0);
        tv[8]  = mk(1, 8'h22, 8'h11, 8'h22, 0, 0, 8'h22, 1, 0, 0, 0, 0, 3, 3, 0);
        tv[9]  = mk(1, 8'h22, 8'h11, 8'h22, 0, 0, 8'h22, 1, 1, 2, 1, 0, 3, 4, 0);
        tv[10] = mk(0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h22, 0, 2, 2, 0, 0, 3, 4, 0);
        tv[11] = mk(1, 8'h33, 8'h33, 8'h33, 0, 0, 8'h33, 1, 2, 2, 0, 0, 3, 4, 0);
        tv[12] = mk(1, 8'h33, 8'h33, 8'h33, 0, 0, 8'h33, 1, 0, 0, 0, 0, 3, 4, 0);
        tv[13] = mk(1, 8'h01, 8'h00, 8'h02, 0, 0, 8'h00, 1, 0, 0, 0, 0, 4, 4, 1);
        tv[14] = mk(1, 8'h01, 8'h00, 8'h02, 0, 0, 8'h00, 1, 0, 0, 0, 0, 5, 4, 2);
        tv[15] = mk(1, 8'h01, 8'h00, 8'h02, 0, 0, 8'h00, 1, 0, 0, 0, 0, 6, 4, 3);
        tv[16] = mk(1, 8'h01, 8'h00, 8'h02, 0, 0, 8'h00, 1, 1, 1, 1, 0, 7, 4, 4);
        tv[17] = mk(1, 8'h00, 8'h00, 8'h03, 0, 0, 8'h00, 0, 3, 1, 0, 1, 7, 4, 4);
        tv[18] = mk(1, 8'h44, 8'h44, 8'h44, 0, 0, 8'h00, 0, 3, 1, 0, 1, 7, 4, 4);
        tv[19] = mk(0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h00, 0, 3, 1, 0, 1, 0, 0, 0);

        // Reset state and directed table
        do_reset();
        #1;
        check_all("reset", 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            apply(tv[i].v, tv[i].ia, tv[i].ib, tv[i].ic, tv[i].ack, tv[i].clr);
            check_all($sformatf("vec%0d", i), tv[i].ey, tv[i].eyv, tv[i].est, tv[i].efid,
                      tv[i].ereq, tv[i].eunc, tv[i].ea, tv[i].eb, tv[i].ec);
        end

        // Ack in NORMAL is ignored; RECOVER falls back to DEGRADED on masked mismatch
        do_reset();
        apply(0, 8'h00, 8'h00, 8'h00, 1, 0);
        check_all("ack_ignored", 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) apply(1, 8'h00, 8'h00, 8'h0F, 0, 0);
        check_all("deg_c", 8'h00, 1, 1, 3, 1, 0, 0, 0, 4);
        apply(0, 8'h00, 8'h00, 8'h00, 1, 0);
        check_all("rec_c", 8'h00, 0, 2, 3, 0, 0, 0, 0, 4);
        apply(1, 8'h00, 8'h00, 8'h01, 0, 0);
        check_all("rec_back", 8'h00, 1, 1, 3, 1, 0, 0, 0, 5);
        apply(1, 8'h00, 8'h00, 8'h00, 1, 0);
        check_all("rec_again", 8'h00, 1, 2, 3, 0, 0, 0, 0, 5);
        apply(1, 8'h00, 8'h00, 8'h00, 0, 0);
        check_all("rec_one", 8'h00, 1, 2, 3, 0, 0, 0, 0, 5);
        apply(1, 8'h00, 8'h00, 8'h00, 0, 0);
        check_all("rec_done", 8'h00, 1, 0, 0, 0, 0, 0, 0, 5);

        // Asynchronous reset in the middle of RECOVER, then clear-vs-increment
        for (int i = 0; i < 4; i++) apply(1, 8'h00, 8'h00, 8'h0F, 0, 0);
        apply(0, 8'h00, 8'h00, 8'h00, 1, 0);
        check("pre_async.state", 32'(state), 32'd2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all("async_rst", 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        valid_in = 1'b1; a = 8'hFF; b = 8'h00; c = 8'h00; resync_ack = 1'b0; clr_cnt = 1'b1;
        #1;
        check_all("post_release", 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_all("clr_priority", 8'h00, 1, 0, 0, 0, 0, 0, 0, 0);

        // Error counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) apply(1, 8'hFF, 8'h00, 8'h00, 0, 0);
        check_all("saturate", 8'h00, 1, 1, 1, 1, 0, 8'hFF, 0, 0);

        // Randomized traffic against the reference model
        fc = 3;
        base = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 300 == 0) begin
                do_reset();
                model_reset();
            end
            if (cyc % 40 == 0) begin
                fc   = $urandom_range(0, 3);
                base = 8'($urandom);
            end
            if ($urandom_range(0, 9) == 0) base = 8'($urandom);
            d[0] = base; d[1] = base; d[2] = base;
            if (fc < 3 && $urandom_range(0, 3) != 0)
                d[fc] = base ^ 8'($urandom_range(1, 255));
            if ($urandom_range(0, 40) == 0) begin
                int j;
                j = $urandom_range(0, 2);
                d[j] = d[j] ^ 8'h80;
            end
            v   = ($urandom_range(0, 7) != 0);
            ack = ($urandom_range(0, 5) == 0);
            clr = ($urandom_range(0, 60) == 0);
            apply(v, d[0], d[1], d[2], ack, clr);
            model_step(v, d[0], d[1], d[2], ack, clr);
            check_all($sformatf("rnd%0d", cyc), m_y, m_yv[0], 2'(m_state), 2'(m_fault),
                      m_req[0], m_unc[0], 8'(m_cnt[0]), 8'(m_cnt[1]), 8'(m_cnt[2]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
